alu_result_stage: RTL

- Registered stage directly downstream of the 16-bit add/sub datapath.
- Captures each result together with its carry-out and operand sign bits.
- Derives Z/N/C/V flags and buffers up to two results in a skid buffer.
- Presents buffered results to register-file writeback over a valid/ready handshake, and maintains the architectural status-flag register.

---
 rtl/alu_result_stage_if.sv | 37 +++
 rtl/alu_result_stage.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the add/sub datapath, the result stage and writeback.
// The stage uses the slave view; the producer/consumer side uses the master view.
interface alu_result_stage_if #(
    parameter int WIDTH  = 16,
    parameter int DEST_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_result;
    logic              in_cout;
    logic              in_sub;
    logic              in_a_msb;
    logic              in_b_msb;
    logic [DEST_W-1:0] in_dest;
    logic              in_setf;

    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_result;
    logic [DEST_W-1:0] out_dest;
    logic [3:0]        out_flags;
    logic [3:0]        status_flags;

    modport master (
        output in_valid, in_result, in_cout, in_sub, in_a_msb, in_b_msb, in_dest, in_setf,
        input  in_ready,
        input  out_valid, out_result, out_dest, out_flags, status_flags,
        output out_ready
    );

    modport slave (
        input  in_valid, in_result, in_cout, in_sub, in_a_msb, in_b_msb, in_dest, in_setf,
        output in_ready,
        output out_valid, out_result, out_dest, out_flags, status_flags,
        input  out_ready
    );
endinterface

// File: rtl/alu_result_stage.sv
// Result stage after the add/sub datapath: derives Z/N/C/V, holds up to two
// results in a head/tail skid buffer and maintains the architectural flags.
module alu_result_stage #(
    parameter int WIDTH  = 16,
    parameter int DEST_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    alu_result_stage_if.slave    bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0]  result;
        logic [DEST_W-1:0] dest;
        logic [3:0]        flags;
        logic              setf;
    } entry_t;

    state_t state;
    state_t state_next;

    entry_t head;
    entry_t tail;
    entry_t in_entry;

    logic [3:0] status;
    logic       in_ready;
    logic       out_valid;
    logic       push;
    logic       pop;
    logic       load_head_in;
    logic       load_head_tail;
    logic       load_tail;
    logic       update_status;

    logic       flag_z;
    logic       flag_n;
    logic       flag_c;
    logic       flag_v;
    logic       r_msb;

    // C is a borrow on SUB; V compares operand signs against the result sign,
    // with B's sign effectively inverted for SUB.
    always_comb begin
        r_msb  = bus.in_result[WIDTH-1];
        flag_z = (bus.in_result == '0);
        flag_n = r_msb;
        flag_c = bus.in_sub ? ~bus.in_cout : bus.in_cout;
        if (bus.in_sub) begin
            flag_v = (bus.in_a_msb != bus.in_b_msb) & (r_msb != bus.in_a_msb);
        end else begin
            flag_v = (bus.in_a_msb == bus.in_b_msb) & (r_msb != bus.in_a_msb);
        end
        in_entry.result = bus.in_result;
        in_entry.dest   = bus.in_dest;
        in_entry.flags  = {flag_z, flag_n, flag_c, flag_v};
        in_entry.setf   = bus.in_setf;
    end

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;

    always_comb begin
        state_next     = state;
        load_head_in   = 1'b0;
        load_head_tail = 1'b0;
        load_tail      = 1'b0;
        update_status  = pop & head.setf & ~flush;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state_next   = ONE;
                        load_head_in = 1'b1;
                    end
                end
                ONE: begin
                    case ({push, pop})
                        2'b11: load_head_in = 1'b1;
                        2'b10: begin
                            state_next = FULL;
                            load_tail  = 1'b1;
                        end
                        2'b01: state_next = EMPTY;
                        default: state_next = ONE;
                    endcase
                end
                FULL: begin
                    if (pop) begin
                        state_next     = ONE;
                        load_head_tail = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Head data is left untouched when the buffer drains so the outputs hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            head   <= '0;
            tail   <= '0;
            status <= '0;
        end else begin
            if (load_head_in) begin
                head <= in_entry;
            end else if (load_head_tail) begin
                head <= tail;
            end
            if (load_tail) begin
                tail <= in_entry;
            end
            if (update_status) begin
                status <= head.flags;
            end
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid;
    assign bus.out_result   = head.result;
    assign bus.out_dest     = head.dest;
    assign bus.out_flags    = head.flags;
    assign bus.status_flags = status;

endmodule
